// File: rtl/bitcnt_sched_if.sv
// Request/response bundle between requesting pipelines and bitcnt_sched.
// The master side drives requests and rsp_ready; the slave side is the scheduler.
interface bitcnt_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ*3-1:0]  req_func;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_data;
    logic               rsp_err;
    logic               busy;
    logic [31:0]        op_count;

    modport master (
        output req_valid, req_data, req_func, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        input  busy, op_count
    );

    modport slave (
        input  req_valid, req_data, req_func, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        output busy, op_count
    );
endinterface

// File: rtl/bitcnt_sched.sv
// Round-robin scheduler sharing one clz/ctz/popcount unit among NREQ requesters.
// Grant in IDLE, compute in EXEC, hold the tagged response in RESP.
module bitcnt_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic         clock,
    input  logic         reset,
    bitcnt_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_q;
    logic [63:0]     op_data_q;
    logic [2:0]      op_func_q;
    logic [IDW-1:0]  op_id_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [63:0]     rsp_data_q;
    logic            rsp_err_q;
    logic [31:0]     cnt_q;

    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] ready;
    int              idx;

    // Scan from the highest offset down so the nearest valid at/after rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == IDLE && gnt_vld) ready[gnt_id] = 1'b1;
    end

    logic [31:0] lo;
    logic [6:0]  clz64, clz32, ctz64, ctz32, pop64, pop32, res;
    logic        illegal;
    logic [63:0] dout_data;

    always_comb begin
        lo    = op_data_q[31:0];
        clz64 = 7'd64;
        clz32 = 7'd32;
        ctz64 = 7'd64;
        ctz32 = 7'd32;
        pop64 = '0;
        pop32 = '0;
        for (int i = 0; i < 64; i++) begin
            if (op_data_q[i]) clz64 = 7'(63 - i);
            pop64 = pop64 + 7'(op_data_q[i]);
        end
        for (int i = 63; i >= 0; i--) begin
            if (op_data_q[i]) ctz64 = 7'(i);
        end
        for (int i = 0; i < 32; i++) begin
            if (lo[i]) clz32 = 7'(31 - i);
            pop32 = pop32 + 7'(lo[i]);
        end
        for (int i = 31; i >= 0; i--) begin
            if (lo[i]) ctz32 = 7'(i);
        end
        case (op_func_q)
            3'b000:  res = clz64;
            3'b001:  res = clz32;
            3'b010:  res = ctz64;
            3'b011:  res = ctz32;
            3'b100:  res = pop64;
            3'b101:  res = pop32;
            default: res = '0;
        endcase
    end

    assign illegal   = (op_func_q[2:1] == 2'b11);
    assign dout_data = {57'b0, res};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            op_data_q   <= '0;
            op_func_q   <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        op_data_q <= bus.req_data[64*gnt_id +: 64];
                        op_func_q <= bus.req_func[3*gnt_id +: 3];
                        op_id_q   <= gnt_id;
                        rr_q      <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                        cnt_q     <= cnt_q + 32'd1;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= illegal ? 64'd0 : dout_data;
                    rsp_err_q   <= illegal;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_bitcnt_sched.sv
// Bench for bitcnt_sched: directed table, hand sequences for stall/reset,
// and a randomized run scored against a bit-counting reference model.
module tb_bitcnt_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bitcnt_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    bitcnt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f,
                                          input logic [63:0] d);
        logic [63:0] v;
        int w, n;
        v = f[0] ? {32'b0, d[31:0]} : d;
        w = f[0] ? 32 : 64;
        case (f[2:1])
            2'b00: begin
                n = 0;
                while (v != 0) begin
                    v = v >> 1;
                    n++;
                end
                return 64'(w - n);
            end
            2'b01: begin
                if (v == 0) return 64'(w);
                return 64'($countones((v & (~v + 64'd1)) - 64'd1));
            end
            2'b10:   return 64'($countones(v));
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rand_data();
        case ($urandom_range(3))
            0:       return 64'd0;
            1:       return {32'($urandom), 32'h0};
            2:       return 64'd1 << $urandom_range(63);
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic set_req(input int i, input logic [2:0] f,
                           input logic [63:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_data[64*i +: 64]  = d;
        bus.req_func[3*i +: 3]    = f;
    endtask

    task automatic wait_grant(output int waited);
        waited = 99;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.req_ready != 0) begin
                waited = c;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string nm, input int i, input logic [2:0] f,
                          input logic [63:0] d, input logic [63:0] exp,
                          input logic err, input int stall);
        int waited;
        logic [31:0] c0;
        @(negedge clock);
        set_req(i, f, d);
        bus.rsp_ready = (stall == 0);
        wait_grant(waited);
        chk({nm, " grant"}, bus.req_ready, 64'd1 << i);
        chk({nm, " grant_wait"}, waited, 0);
        c0 = bus.op_count;
        @(posedge clock);
        #1;
        bus.req_valid[i] = 1'b0;
        @(negedge clock);
        chk({nm, " exec_valid"}, bus.rsp_valid, 0);
        chk({nm, " exec_busy"}, bus.busy, 1);
        chk({nm, " op_count"}, bus.op_count, c0 + 32'd1);
        @(negedge clock);
        chk({nm, " rsp_valid"}, bus.rsp_valid, 1);
        chk({nm, " rsp_data"}, bus.rsp_data, exp);
        chk({nm, " rsp_id"}, bus.rsp_id, i);
        chk({nm, " rsp_err"}, bus.rsp_err, err);
        repeat (stall) begin
            @(negedge clock);
            chk({nm, " hold_valid"}, bus.rsp_valid, 1);
            chk({nm, " hold_data"}, bus.rsp_data, exp);
            chk({nm, " hold_id"}, bus.rsp_id, i);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        chk({nm, " done_valid"}, bus.rsp_valid, 0);
        chk({nm, " done_busy"}, bus.busy, 0);
    endtask

    typedef struct {
        int          idx;
        logic [2:0]  f;
        logic [63:0] d;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] data;
        logic        err;
    } rsp_t;

    vec_t tbl[12];
    rsp_t q[$];
    int   order[5];

    initial begin
        int ng, nr, last, gid, waited, w, gprev, ngr;
        logic [2:0]  pf[NREQ];
        logic [63:0] pd[NREQ];
        logic [NREQ-1:0] expr;
        logic stalled;
        rsp_t sv, r;

        tbl[0]  = '{0, 3'b000, 64'h1, 64'd63, 1'b0};
        tbl[1]  = '{1, 3'b111, 64'h1234, 64'd0, 1'b1};
        tbl[2]  = '{1, 3'b001, 64'hFFFF_FFFF_0000_0000, 64'd32, 1'b0};
        tbl[3]  = '{2, 3'b011, 64'hFFFF_FFFF_8000_0000, 64'd31, 1'b0};
        tbl[4]  = '{3, 3'b000, 64'h0, 64'd64, 1'b0};
        tbl[5]  = '{0, 3'b010, 64'h0, 64'd64, 1'b0};
        tbl[6]  = '{1, 3'b010, 64'h8000_0000_0000_0000, 64'd63, 1'b0};
        tbl[7]  = '{2, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b0};
        tbl[8]  = '{3, 3'b101, 64'hFFFF_FFFF_0000_000F, 64'd4, 1'b0};
        tbl[9]  = '{0, 3'b110, 64'h5, 64'd0, 1'b1};
        tbl[10] = '{1, 3'b001, 64'h0000_0000_0000_FFFF, 64'd16, 1'b0};
        tbl[11] = '{2, 3'b011, 64'h10, 64'd4, 1'b0};
        order = '{0, 1, 2, 3, 0};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_func  = '0;
        bus.rsp_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst op_count", bus.op_count, 0);
        chk("rst rsp_id", bus.rsp_id, 0);
        chk("rst rsp_data", bus.rsp_data, 0);
        chk("rst rsp_err", bus.rsp_err, 0);
        chk("rst req_ready", bus.req_ready, 0);
        reset = 1'b0;

        for (int t = 0; t < 12; t++)
            run_op($sformatf("vec%0d", t), tbl[t].idx, tbl[t].f, tbl[t].d,
                   tbl[t].exp, tbl[t].err, 0);
        chk("vec op_count", bus.op_count, 12);

        // all requesters hammering: rotation and 3-cycle cadence
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'b100, 64'hFF);
        bus.rsp_ready = 1'b1;
        ng = 0; nr = 0; last = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            #1;
            if (bus.req_ready != 0) begin
                gid = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid = i;
                if (ng < 5) chk("rr order", gid, order[ng]);
                if (ng > 0) chk("rr spacing", cyc - last, 3);
                last = cyc;
                ng++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (nr < 5) chk("rr rsp_id", bus.rsp_id, order[nr]);
                chk("rr rsp_data", bus.rsp_data, 8);
                nr++;
            end
            @(negedge clock);
        end
        chk("rr grants", ng, 5);
        chk("rr responses", nr, 5);
        bus.req_valid = '0;
        repeat (5) @(negedge clock);

        // stalled consumer with another requester waiting
        set_req(2, 3'b011, 64'hFFFF_FFFF_8000_0000);
        bus.rsp_ready = 1'b0;
        wait_grant(waited);
        chk("stall grant", bus.req_ready, 4'b0100);
        @(posedge clock);
        #1;
        bus.req_valid[2] = 1'b0;
        set_req(0, 3'b100, 64'hF);
        @(negedge clock);
        chk("stall exec ready", bus.req_ready, 0);
        @(negedge clock);
        chk("stall rsp_data", bus.rsp_data, 31);
        chk("stall rsp_id", bus.rsp_id, 2);
        repeat (4) begin
            @(negedge clock);
            chk("stall hold_valid", bus.rsp_valid, 1);
            chk("stall hold_data", bus.rsp_data, 31);
            chk("stall hold_id", bus.rsp_id, 2);
            chk("stall hold_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("handshake ready", bus.req_ready, 0);
        @(negedge clock);
        #1;
        chk("after hs ready", bus.req_ready, 4'b0001);
        chk("after hs valid", bus.rsp_valid, 0);
        @(posedge clock);
        #1;
        bus.req_valid[0] = 1'b0;
        repeat (2) @(negedge clock);
        chk("next rsp_data", bus.rsp_data, 4);
        chk("next rsp_id", bus.rsp_id, 0);
        @(negedge clock);

        // reset while a response is pending
        set_req(3, 3'b100, 64'h3);
        bus.rsp_ready = 1'b0;
        wait_grant(waited);
        @(posedge clock);
        #1;
        bus.req_valid[3] = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid rsp_valid", bus.rsp_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("mid rst valid", bus.rsp_valid, 0);
        chk("mid rst busy", bus.busy, 0);
        chk("mid rst count", bus.op_count, 0);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) bus.req_valid[i] = 1'b1;
        #1;
        chk("mid rst rr_ptr", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        repeat (3) begin
            @(negedge clock);
            chk("mid rst no rsp", bus.rsp_valid, 0);
        end

        // randomized traffic against the scoreboard
        w = 0; gprev = -1; ngr = 0; stalled = 1'b0;
        sv = '{0, 64'd0, 1'b0};
        for (int i = 0; i < NREQ; i++) begin
            pf[i] = 3'b000;
            pd[i] = 64'd0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clock);
            if (gprev >= 0) bus.req_valid[gprev] = 1'b0;
            gprev = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (cyc < 760 && !bus.req_valid[i]) begin
                    if ($urandom_range(3) == 0) begin
                        pf[i] = 3'($urandom_range(7));
                        pd[i] = rand_data();
                        set_req(i, pf[i], pd[i]);
                    end
                end else if (cyc < 760 && $urandom_range(49) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = (cyc >= 760) || ($urandom_range(2) != 0);
            #1;
            expr = '0;
            if (!bus.busy) begin
                gid = -1;
                for (int k = 0; k < NREQ; k++)
                    if (gid < 0 && bus.req_valid[(w + k) % NREQ])
                        gid = (w + k) % NREQ;
                if (gid >= 0) begin
                    expr[gid] = 1'b1;
                    q.push_back('{gid, model(pf[gid], pd[gid]),
                                  pf[gid][2:1] == 2'b11});
                    w = (gid + 1) % NREQ;
                    gprev = gid;
                    ngr++;
                end
            end
            chk("rnd req_ready", bus.req_ready, expr);
            if (stalled) begin
                chk("rnd hold_valid", bus.rsp_valid, 1);
                chk("rnd hold_data", bus.rsp_data, sv.data);
                chk("rnd hold_id", bus.rsp_id, sv.id);
                chk("rnd hold_err", bus.rsp_err, sv.err);
            end
            stalled = 1'b0;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rnd spurious rsp", 1, 0);
                end else begin
                    r = q.pop_front();
                    chk("rnd rsp_id", bus.rsp_id, r.id);
                    chk("rnd rsp_data", bus.rsp_data, r.data);
                    chk("rnd rsp_err", bus.rsp_err, r.err);
                end
            end else if (bus.rsp_valid) begin
                stalled = 1'b1;
                sv = '{int'(bus.rsp_id), bus.rsp_data, bus.rsp_err};
            end
        end
        chk("rnd drained", q.size(), 0);
        chk("rnd op_count", bus.op_count, ngr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
